axis_fifo_pkt: RTL and testbench

Parametrised AXI-Stream FIFO with first-word fall-through output, `tlast` framing, a fill-level output and programmable almost-full/almost-empty flags. An optional packet mode withholds output until a complete packet (terminated by `last`) is stored. Packet mode has a deadlock-free fallback for packets longer than the FIFO. It sits between stream producers and consumers in the datapath and is the next generation of the single-channel counter-based FIFO.

---
 rtl/axis_fifo_pkt.sv | 145 ++++++++++++++
 tb/tb_axis_fifo_pkt.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: AXI-Stream FIFO, first-word fall-through output.
// Optional store-and-forward packet mode with oversize cut-through.
module axis_fifo_pkt #(
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int PACKET_MODE        = 0,
  parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_last,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        almost_full,
  output logic                        almost_empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(ALMOST_FULL_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(ALMOST_EMPTY_LEVEL);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } cut_t;

  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [LW-1:0]       r_pkt_cnt;
  cut_t                r_state;
  cut_t                w_state_nxt;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_full;
  logic                w_empty;
  logic                w_pkt_inc;
  logic                w_pkt_dec;
  logic [DATA_WIDTH:0] w_head;

  assign w_full  = (r_level == DEPTH_L);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  assign s_ready = !w_full;
  assign m_data  = w_head[DATA_WIDTH-1:0];
  assign m_last  = w_head[DATA_WIDTH];

  assign w_wr_en   = s_valid & s_ready;
  assign w_rd_en   = m_valid & m_ready;
  assign w_pkt_inc = w_wr_en & s_last;
  assign w_pkt_dec = w_rd_en & m_last;

  assign level        = r_level;
  assign almost_full  = (r_level >= AF_L);
  assign almost_empty = (r_level <= AE_L);

  // Head is visible once stored; packet mode also needs a whole packet
  // or an oversize packet being released in cut-through.
  always_comb begin
    m_valid = !w_empty;
    if (PACKET_MODE != 0)
      m_valid = !w_empty &&
                ((r_pkt_cnt != '0) || (r_state == ST_PASS));
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge aclk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= {s_last, s_data};
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Stored beat count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_level <= '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + ONE_L;
        2'b01:   r_level <= r_level - ONE_L;
        default: r_level <= r_level;
      endcase
    end
  end

  // Complete packets held (last beats stored but not yet read).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + ONE_L;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - ONE_L;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Cut-through state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Full with no complete packet would deadlock: release the head
  // packet until its last beat leaves.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if ((PACKET_MODE != 0) && w_full && (r_pkt_cnt == '0))
          w_state_nxt = ST_PASS;
      ST_PASS:
        if (w_pkt_dec)
          w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// tb_axis_fifo_pkt: scoreboard bench for word-mode and
// packet-mode instances of axis_fifo_pkt.
module tb_axis_fifo_pkt;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [DW-1:0] w_s_data, w_m_data;
  logic          w_s_last, w_s_valid, w_s_ready;
  logic          w_m_last, w_m_valid, w_m_ready;
  logic          w_af, w_ae;
  logic [4:0]    w_level;

  logic [DW-1:0] p_s_data, p_m_data;
  logic          p_s_last, p_s_valid, p_s_ready;
  logic          p_m_last, p_m_valid, p_m_ready;
  logic          p_af, p_ae;
  logic [4:0]    p_level;

  axis_fifo_pkt #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PACKET_MODE(0)
  ) u_word (
    .aclk(aclk), .aresetn(aresetn),
    .s_data(w_s_data), .s_last(w_s_last),
    .s_valid(w_s_valid), .s_ready(w_s_ready),
    .m_data(w_m_data), .m_last(w_m_last),
    .m_valid(w_m_valid), .m_ready(w_m_ready),
    .level(w_level), .almost_full(w_af),
    .almost_empty(w_ae)
  );

  axis_fifo_pkt #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PACKET_MODE(1)
  ) u_pkt (
    .aclk(aclk), .aresetn(aresetn),
    .s_data(p_s_data), .s_last(p_s_last),
    .s_valid(p_s_valid), .s_ready(p_s_ready),
    .m_data(p_m_data), .m_last(p_m_last),
    .m_valid(p_m_valid), .m_ready(p_m_ready),
    .level(p_level), .almost_full(p_af),
    .almost_empty(p_ae)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [DW:0] wq[$];
  logic [DW:0] pq[$];
  logic [DW:0] w_exp, p_exp;
  bit          p_pass;
  bit          p_nxt;
  int          p_lasts;
  int          p_reads = 0;

  // Word-mode scoreboard
  always @(negedge aclk) begin
    if (!aresetn) begin
      wq.delete();
    end else begin
      check("w_level", w_level, wq.size());
      check("w_s_ready", w_s_ready, wq.size() != DEPTH);
      check("w_m_valid", w_m_valid, wq.size() != 0);
      check("w_af", w_af, wq.size() >= DEPTH - 2);
      check("w_ae", w_ae, wq.size() <= 2);
      if (w_m_valid && w_m_ready && wq.size() != 0) begin
        w_exp = wq.pop_front();
        check("w_out", {w_m_last, w_m_data}, w_exp);
      end
      if (w_s_valid && w_s_ready)
        wq.push_back({w_s_last, w_s_data});
    end
  end

  // Packet-mode scoreboard with cut-through model
  always @(negedge aclk) begin
    if (!aresetn) begin
      pq.delete();
      p_pass = 1'b0;
    end else begin
      p_lasts = 0;
      foreach (pq[i])
        if (pq[i][DW]) p_lasts++;
      check("p_level", p_level, pq.size());
      check("p_s_ready", p_s_ready, pq.size() != DEPTH);
      check("p_m_valid", p_m_valid,
            (pq.size() != 0) && (p_lasts != 0 || p_pass));
      check("p_af", p_af, pq.size() >= DEPTH - 2);
      check("p_ae", p_ae, pq.size() <= 2);
      p_nxt = p_pass;
      if (!p_pass && pq.size() == DEPTH && p_lasts == 0)
        p_nxt = 1'b1;
      if (p_m_valid && p_m_ready && pq.size() != 0) begin
        p_exp = pq.pop_front();
        check("p_out", {p_m_last, p_m_data}, p_exp);
        if (p_pass && p_exp[DW]) p_nxt = 1'b0;
        p_reads++;
      end
      if (p_s_valid && p_s_ready)
        pq.push_back({p_s_last, p_s_data});
      p_pass = p_nxt;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic w_put(input logic [DW-1:0] d, input logic l);
    w_s_data  = d;
    w_s_last  = l;
    w_s_valid = 1'b1;
    tick();
    w_s_valid = 1'b0;
  endtask

  task automatic p_send(input logic [DW-1:0] d, input logic l);
    bit acc;
    int k;
    k = 0;
    p_s_data  = d;
    p_s_last  = l;
    p_s_valid = 1'b1;
    do begin
      acc = p_s_ready;
      tick();
      k++;
    end while (!acc && k < 50);
    if (!acc) check("p_send_timeout", 0, 1);
    p_s_valid = 1'b0;
  endtask

  task automatic w_drain();
    int k;
    k = 0;
    w_m_ready = 1'b1;
    while (w_level != 0 && k < 100) begin
      tick();
      k++;
    end
    check("w_drain_level", w_level, 0);
  endtask

  task automatic p_drain();
    int k;
    k = 0;
    p_m_ready = 1'b1;
    while (p_level != 0 && k < 100) begin
      tick();
      k++;
    end
    check("p_drain_level", p_level, 0);
  endtask

  int base;

  initial begin
    w_s_data = '0; w_s_last = 0; w_s_valid = 0; w_m_ready = 0;
    p_s_data = '0; p_s_last = 0; p_s_valid = 0; p_m_ready = 0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_w_s_ready", w_s_ready, 1);
    check("rst_w_m_valid", w_m_valid, 0);
    check("rst_w_level", w_level, 0);
    check("rst_w_ae", w_ae, 1);
    check("rst_w_af", w_af, 0);
    check("rst_p_s_ready", p_s_ready, 1);
    check("rst_p_m_valid", p_m_valid, 0);
    check("rst_p_level", p_level, 0);
    check("rst_p_ae", p_ae, 1);
    check("rst_p_af", p_af, 0);
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) w_put(32'hA0 + i, 1'b0);
    check("mid_level_5", w_level, 5);
    aresetn = 1'b0;
    #1;
    check("mid_rst_level", w_level, 0);
    check("mid_rst_m_valid", w_m_valid, 0);
    tick();
    aresetn = 1'b1;
    w_put(32'hB0, 1'b0);
    check("after_rst_valid", w_m_valid, 1);
    check("after_rst_data", w_m_data, 32'hB0);
    w_put(32'hB1, 1'b0);
    w_put(32'hB2, 1'b1);
    w_drain();

    w_m_ready = 1'b0;
    for (int i = 0; i < 16; i++) w_put(i, i == 15);
    check("fill_level", w_level, 16);
    check("fill_s_ready", w_s_ready, 0);
    check("fill_af", w_af, 1);
    w_s_data  = 32'h10;
    w_s_valid = 1'b1;
    tick();
    tick();
    check("held_17th_level", w_level, 16);
    w_s_valid = 1'b0;
    w_drain();

    w_m_ready = 1'b0;
    for (int i = 0; i < 8; i++) w_put(32'h100 + i, 1'b0);
    w_s_valid = 1'b1;
    w_m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w_s_data = 32'h200 + i;
      w_s_last = i[0];
      tick();
    end
    w_s_valid = 1'b0;
    w_m_ready = 1'b0;
    check("conc_level", w_level, 8);
    for (int i = 0; i < 8; i++) w_put(32'h300 + i, 1'b0);
    check("refill_level", w_level, 16);
    w_s_data  = 32'h400;
    w_s_valid = 1'b1;
    w_m_ready = 1'b1;
    tick();
    check("full_read_only", w_level, 15);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("level15_tput", w_level, 15);
      w_s_data = w_s_data + 1;
    end
    w_s_valid = 1'b0;
    w_drain();

    p_m_ready = 1'b1;
    base = p_reads;
    p_send(32'hC0, 1'b0);
    check("pkt_hold1", p_m_valid, 0);
    p_send(32'hC1, 1'b0);
    check("pkt_hold2", p_m_valid, 0);
    p_send(32'hC2, 1'b1);
    check("pkt_release", p_m_valid, 1);
    check("pkt_head", p_m_data, 32'hC0);
    p_drain();
    check("pkt_reads", p_reads - base, 3);

    p_m_ready = 1'b0;
    p_send(32'hD0, 1'b0);
    p_send(32'hD1, 1'b1);
    p_send(32'hD2, 1'b0);
    p_send(32'hD3, 1'b0);
    p_send(32'hD4, 1'b1);
    check("pkt_cnt_2", u_pkt.r_pkt_cnt, 2);
    check("pkt_b2b_level", p_level, 5);
    p_drain();

    p_m_ready = 1'b1;
    base = p_reads;
    for (int i = 0; i < 16; i++) p_send(32'hE0 + i, 1'b0);
    check("ovs_level", p_level, 16);
    check("ovs_m_valid_0", p_m_valid, 0);
    check("ovs_idle", u_pkt.r_state, 0);
    tick();
    check("ovs_pass", u_pkt.r_state, 1);
    check("ovs_m_valid_1", p_m_valid, 1);
    for (int i = 16; i < 20; i++) p_send(32'hE0 + i, i == 19);
    p_drain();
    check("ovs_reads", p_reads - base, 20);
    check("ovs_back_idle", u_pkt.r_state, 0);

    for (int c = 0; c < 10000; c++) begin
      w_s_valid = 1'($urandom_range(0, 1));
      w_s_data  = $urandom;
      w_s_last  = ($urandom_range(0, 3) == 0);
      w_m_ready = 1'($urandom_range(0, 1));
      p_s_valid = 1'($urandom_range(0, 1));
      p_s_data  = $urandom;
      p_s_last  = ($urandom_range(0, 3) == 0);
      p_m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    w_s_valid = 1'b0;
    w_drain();
    p_send(32'hF00D, 1'b1);
    p_drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
